conv_stream_ctrl: RTL and testbench

- Frame-level sequencer and flow controller for a fixed-latency streaming convolution datapath, such as the 3-tap MAC chain.
- The datapath has no backpressure, so this block takes a ready/valid image stream and issues a beat to the datapath only when it holds a credit.
- Each credit guarantees space in an on-chip result FIFO. Results drain to a ready/valid output with a last flag.
- It sits between the pixel line source and the downstream result consumer, and counts one frame of cfg_len beats per start.

---
 rtl/conv_pkg.sv | 20 ++
 rtl/result_fifo.sv | 53 +++++
 rtl/conv_stream_ctrl.sv | 126 ++++++++++++
 tb/tb_conv_stream_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and default sizing for the convolution stream controller.
// Width helpers keep the credit counter wide enough to hold a full FIFO worth of credit.
package conv_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int DEF_IMG_WIDTH  = 16;
  localparam int DEF_KER_WIDTH  = 16;
  localparam int DEF_IMG_NB     = 3;
  localparam int DEF_LATENCY    = 18;
  localparam int DEF_FIFO_DEPTH = 32;

  localparam int RES_WIDTH = DEF_IMG_WIDTH + DEF_KER_WIDTH + 1;
  localparam int CREDIT_W  = $clog2(DEF_FIFO_DEPTH + 1);

  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/result_fifo.sv
// First-word-fall-through result FIFO holding {last, data}; head visible the cycle after write.
// Writes into a full FIFO are dropped and reads from an empty one are ignored; the caller's credits prevent both.
module result_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   wr_last,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_last,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH:0] mem [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [WIDTH:0] head;
  logic           full, empty, wr_ok, rd_ok;

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == PW'(DEPTH));
  assign empty = (count == '0);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= {wr_last, wr_data};
  end

  // Head is forced to zero when empty so stale entries never leak onto the output.
  assign head     = mem[rd_ptr[AW-1:0]];
  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : head[WIDTH-1:0];
  assign rd_last  = !empty && head[WIDTH];

endmodule

// File: rtl/conv_stream_ctrl.sv
// Frame sequencer and credit-based flow control around a fixed-latency, backpressure-free datapath.
// Accept to m_valid is LATENCY+2 cycles with the FIFO empty; s_ready drops when no FIFO credit remains.
module conv_stream_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int KER_WIDTH  = DEF_KER_WIDTH,
  parameter int IMG_NB     = DEF_IMG_NB,
  parameter int LATENCY    = DEF_LATENCY,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [15:0]                   cfg_len,
  output logic                          busy,
  output logic                          done,
  input  logic [IMG_WIDTH*IMG_NB-1:0]   s_img,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [IMG_WIDTH*IMG_NB-1:0]   dp_img,
  output logic                          dp_val,
  input  logic [IMG_WIDTH+KER_WIDTH:0]  dp_result,
  output logic [IMG_WIDTH+KER_WIDTH:0]  m_result,
  output logic                          m_valid,
  output logic                          m_last,
  input  logic                          m_ready
);

  localparam int RW  = IMG_WIDTH + KER_WIDTH + 1;
  localparam int CW  = credit_width(FIFO_DEPTH);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  state_t         state, state_nxt;
  logic [15:0]    len_q, cnt_q;
  logic [CW-1:0]  credits;
  logic           acc, pop, beat_last;
  logic           dp_last;
  logic [LATENCY-1:0] vld_dl, last_dl;
  logic           fifo_wr;
  logic [FCW-1:0] fifo_count;
  logic           in_flight_zero, fifo_drains, drain_done;

  assign acc       = s_valid && s_ready;
  assign pop       = m_valid && m_ready;
  assign beat_last = (cnt_q + 16'd1 == len_q);

  // Credit not free and not in the FIFO is a beat still inside the datapath.
  assign in_flight_zero = (credits + CW'(fifo_count) == CW'(FIFO_DEPTH));
  assign fifo_drains    = (fifo_count == '0) || ((fifo_count == FCW'(1)) && pop);
  assign drain_done     = in_flight_zero && fifo_drains;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start && cfg_len != '0) state_nxt = RUN;
      RUN:     if (acc && beat_last)       state_nxt = DRAIN;
      DRAIN:   if (drain_done)             state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    s_ready = (state == RUN) && (credits != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q   <= '0;
      cnt_q   <= '0;
      credits <= CW'(FIFO_DEPTH);
      done    <= 1'b0;
      dp_img  <= '0;
      dp_val  <= 1'b0;
      dp_last <= 1'b0;
      vld_dl  <= '0;
      last_dl <= '0;
    end else begin
      credits <= credits + CW'(pop) - CW'(acc);
      done    <= ((state == IDLE) && start && (cfg_len == '0)) ||
                 ((state == DRAIN) && drain_done);
      dp_val  <= acc;
      dp_last <= acc && beat_last;
      if (acc) begin
        dp_img <= s_img;
        cnt_q  <= cnt_q + 16'd1;
      end
      if ((state == IDLE) && start) begin
        len_q <= cfg_len;
        cnt_q <= '0;
      end
      // Tag line mirrors the datapath pipeline so each result meets its own valid/last.
      vld_dl[0]  <= dp_val;
      last_dl[0] <= dp_last;
      for (int i = 1; i < LATENCY; i++) begin
        vld_dl[i]  <= vld_dl[i-1];
        last_dl[i] <= last_dl[i-1];
      end
    end
  end

  assign fifo_wr = vld_dl[LATENCY-1];

  result_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (fifo_wr),
    .wr_data  (dp_result),
    .wr_last  (last_dl[LATENCY-1]),
    .rd_en    (m_ready),
    .rd_data  (m_result),
    .rd_last  (m_last),
    .rd_valid (m_valid),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Bench for conv_stream_ctrl: 3-tap MAC datapath model, queue scoreboard, per-cycle port model.
module tb_conv_stream_ctrl;
  import conv_pkg::*;

  localparam int IW = 16, KW = 16, NB = 3, LAT = 18, DEPTH = 32;
  localparam int RW = RES_WIDTH;

  logic clk = 1'b0;
  logic rst, start, busy, done, s_valid, s_ready, dp_val, m_valid, m_last, m_ready;
  logic [15:0] cfg_len;
  logic [IW*NB-1:0] s_img, dp_img;
  logic [RW-1:0] dp_result, m_result;

  always #5 clk = ~clk;

  conv_stream_ctrl #(
    .IMG_WIDTH(IW), .KER_WIDTH(KW), .IMG_NB(NB), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .busy(busy), .done(done),
    .s_img(s_img), .s_valid(s_valid), .s_ready(s_ready), .dp_img(dp_img), .dp_val(dp_val),
    .dp_result(dp_result), .m_result(m_result), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready)
  );

  // Lane i is weighted by coefficient i+2, i.e. 2/3/4.
  function automatic logic [RW-1:0] mac(input logic [IW*NB-1:0] img);
    logic [RW-1:0] sum;
    sum = '0;
    for (int i = 0; i < NB; i++) sum += RW'(img[i*IW +: IW]) * RW'(i + 2);
    return sum;
  endfunction

  logic [RW-1:0] pipe [LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= dp_val ? mac(dp_img) : '0;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign dp_result = pipe[LAT-1];

  int total = 0, bad = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct { logic [RW-1:0] val; logic last; int t; } exp_t;
  exp_t q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit chk_en = 0;
  bit mb_busy = 0, mb_run = 0, mb_done = 0, mb_dpval = 0;
  logic [IW*NB-1:0] mb_dpimg;
  logic [15:0] mb_len;
  int outst = 0, frame_acc = 0, frame_pops = 0, done_cnt = 0;
  int fa_cyc = 0, fm_cyc = -1, done_cyc = 0, last_pop_cyc = 0;
  bit tbl_on = 0;
  int tbl_bad = 0;
  logic [RW-1:0] tbl_exp;

  always @(negedge clk) begin : model
    bit dn, exp_mv;
    exp_t e;
    if (chk_en) begin
      exp_mv = 1'b0;
      if (q.size() > 0) exp_mv = (q[0].t <= cyc);
      check("busy", busy, mb_busy);
      check("s_ready", s_ready, mb_run && (outst < DEPTH));
      check("done", done, mb_done);
      check("dp_val", dp_val, mb_dpval);
      if (mb_dpval) check("dp_img", dp_img, mb_dpimg);
      check("m_valid", m_valid, exp_mv);
      if (!m_valid) check("m_last_idle", m_last, 0);
      check("credits", dut.credits, DEPTH - outst);
      if (dut.fifo_wr) check("fifo_room", dut.u_fifo.count < DEPTH, 1);
      if (m_valid && fm_cyc < 0) fm_cyc = cyc;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (rst) begin
      q.delete();
      outst = 0; mb_busy = 0; mb_run = 0; mb_done = 0; mb_dpval = 0;
    end else begin
      dn = 1'b0;
      mb_dpval = s_valid && s_ready;
      if (s_valid && s_ready) mb_dpimg = s_img;
      if (!mb_busy && start) begin
        if (cfg_len == 16'd0) dn = 1'b1;
        else begin
          mb_busy = 1; mb_run = 1; mb_len = cfg_len; frame_acc = 0; frame_pops = 0;
        end
      end
      if (s_valid && s_ready) begin
        frame_acc++;
        if (frame_acc == 1) fa_cyc = cyc;
        e.val = mac(s_img);
        e.last = (frame_acc == int'(mb_len));
        e.t = cyc + LAT + 2;
        q.push_back(e);
        outst++;
        if (e.last) mb_run = 0;
      end
      if (m_valid && m_ready) begin
        if (q.size() == 0) check("unexpected_pop", m_valid, 0);
        else begin
          check("m_result", m_result, q[0].val);
          check("m_last", m_last, q[0].last);
          if (tbl_on && m_result !== tbl_exp) tbl_bad++;
          void'(q.pop_front());
          outst--;
          frame_pops++;
          last_pop_cyc = cyc;
        end
      end
      if (mb_busy && !mb_run && outst == 0) begin
        mb_busy = 0;
        dn = 1'b1;
      end
      mb_done = dn;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int len);
    start = 1'b1; cfg_len = 16'(len); s_valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic drive_until_done(input logic [IW*NB-1:0] img, input bit rimg,
                                  input int svp, input int mrp, input int budget);
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      s_valid = ($urandom_range(0, 99) < svp);
      s_img   = rimg ? {16'($urandom), 16'($urandom), 16'($urandom)} : img;
      m_ready = ($urandom_range(0, 99) < mrp);
      tick();
      n++;
    end
    check("done_within_budget", done_cnt - d0, 1);
    s_valid = 1'b0;
    m_ready = 1'b1;
  endtask

  typedef struct { int len; logic [15:0] l0, l1, l2; logic [RW-1:0] exp; } vec_t;
  vec_t tbl[4];

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int d, n;
    rst = 1; start = 0; cfg_len = 0; s_valid = 0; s_img = '0; m_ready = 0;
    repeat (3) tick();
    rst = 0;
    chk_en = 1;

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_dp_val", dp_val, 0);
    check("rst_dp_img", dp_img, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_result", m_result, 0);

    tbl[0] = '{4, 16'd1,     16'd1,     16'd1,     33'd9};
    tbl[1] = '{6, 16'd2,     16'd0,     16'd5,     33'd24};
    tbl[2] = '{3, 16'hffff,  16'hffff,  16'hffff,  33'd589815};
    tbl[3] = '{1, 16'd7,     16'd100,   16'd1000,  33'd4314};
    for (int i = 0; i < 4; i++) begin
      tbl_exp = tbl[i].exp; tbl_bad = 0; tbl_on = 1; fm_cyc = -1;
      start_frame(tbl[i].len);
      drive_until_done({tbl[i].l2, tbl[i].l1, tbl[i].l0}, 0, 100, 100, 300);
      tbl_on = 0;
      check("tbl_pops", frame_pops, tbl[i].len);
      check("tbl_vals", tbl_bad, 0);
      check("tbl_latency", fm_cyc - fa_cyc, LAT + 2);
      check("tbl_done_after_pop", done_cyc - last_pop_cyc, 1);
    end

    // FIFO-full backpressure: only DEPTH beats may enter while the consumer stalls.
    start_frame(100);
    s_valid = 1; s_img = {16'd3, 16'd2, 16'd1}; m_ready = 0;
    repeat (60) tick();
    check("bp_accepted", frame_acc, DEPTH);
    check("bp_s_ready", s_ready, 0);
    check("bp_m_valid", m_valid, 1);
    drive_until_done({16'd3, 16'd2, 16'd1}, 0, 100, 100, 400);
    check("bp_pops", frame_pops, 100);

    d = done_cnt;
    start = 1; cfg_len = 0;
    tick();
    start = 0;
    check("empty_done", done, 1);
    check("empty_busy", busy, 0);
    tick();
    check("empty_done_once", done, 0);
    check("empty_dp_val", dp_val, 0);
    repeat (3) tick();
    check("empty_done_cnt", done_cnt - d, 1);

    start_frame(5);
    s_valid = 1; s_img = {16'd9, 16'd8, 16'd7}; m_ready = 1;
    repeat (3) tick();
    start = 1; cfg_len = 16'd8;
    tick();
    start = 0;
    drive_until_done({16'd9, 16'd8, 16'd7}, 0, 100, 100, 300);
    check("sb_pops", frame_pops, 5);
    d = done_cnt;
    repeat (40) tick();
    check("sb_single_done", done_cnt - d, 0);
    check("sb_idle", busy, 0);

    start_frame(10);
    s_valid = 1; s_img = {16'd4, 16'd5, 16'd6}; m_ready = 1;
    n = 0;
    while (frame_acc < 3 && n < 50) begin
      tick();
      n++;
    end
    check("rm_reached3", frame_acc, 3);
    rst = 1;
    tick();
    rst = 0; s_valid = 0;
    check("rm_m_valid", m_valid, 0);
    check("rm_s_ready", s_ready, 0);
    check("rm_busy", busy, 0);
    start_frame(2);
    drive_until_done({16'd1, 16'd2, 16'd3}, 0, 100, 100, 300);
    check("rm_pops", frame_pops, 2);

    start_frame(1000);
    drive_until_done('0, 1, 70, 60, 20000);
    check("rand_pops", frame_pops, 1000);

    repeat (5) tick();
    check("scoreboard_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
